// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its peer receiver:
// line-state enum, framing levels and the even-parity helper.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_transmitter_if.sv
// Byte-producer side bus of the serial transmitter plus its serial line.
interface serial_transmitter_if;
  import serial_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 write;
  logic                 full;
  logic                 busy;
  logic                 serial_line;

  modport master (output data, write, input full, busy, serial_line);
  modport slave  (input data, write, output full, busy, serial_line);
endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous byte FIFO with registered pointers, count, full and empty flags.
module serial_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push_ok_s, pop_ok_s;

  // Accept/advance logic; a push on a full FIFO is legal when a pop frees a slot
  always_comb begin
    pop_ok_s  = pop && !empty_q;
    push_ok_s = push && (!full_q || pop_ok_s);
    if (push_ok_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else           wr_ptr_d = wr_ptr_q;
    if (pop_ok_s)  rd_ptr_d = rd_ptr_q + AW'(1);
    else           rd_ptr_d = rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == CNTW'(0));
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CNTW'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/serial_transmitter.sv
// UART-style transmitter: strobed byte writes into a FIFO, serialised 8N1 LSB first.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int WR_DIV       = 2
) (
  input  logic                clk,
  input  logic                rst,
  serial_transmitter_if.slave bus
);
  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW  = (WR_DIV > 1) ? $clog2(WR_DIV) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(WR_DIV - 1);
  localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                 strobe_s, baud_end_s;
  logic                 fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_dout_s;
  logic [FCW-1:0]       fifo_count_s;

  serial_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push_s),
    .pop      (fifo_pop_s),
    .data_in  (bus.data),
    .data_out (fifo_dout_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Write-sample phase: write/data are only looked at on the last phase
  always_comb begin
    strobe_s = (phase_q == PHASE_LAST);
    if (strobe_s) phase_d = PW'(0);
    else          phase_d = phase_q + PW'(1);
    fifo_push_s = strobe_s && bus.write && !fifo_full_s;
  end

  // Framing FSM; the line register follows state_q, so it lags the FSM by one clock
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop_s = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    baud_end_s = (baud_q == BAUD_LAST);
    if (state_q == IDLE || baud_end_s) baud_d = CW'(0);
    else                               baud_d = baud_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_dout_s;
`ifdef SERIAL_TX_PARITY_EN
          parity_d   = even_parity(fifo_dout_s);
`endif
          state_d    = START;
        end else begin
          state_d    = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d   = START;
        end
      end
      DATA: begin
        if (baud_end_s) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (baud_end_s) state_d = STOP;
        else            state_d = PARITY;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more bytes are queued
        if (baud_end_s) begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_dout_s;
`ifdef SERIAL_TX_PARITY_EN
            parity_d   = even_parity(fifo_dout_s);
`endif
            state_d    = START;
          end else begin
            state_d    = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_q)
      START:   line_d = START_BIT;
      DATA:    line_d = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  line_d = parity_q;
`endif
      STOP:    line_d = STOP_BIT;
      default: line_d = IDLE_LEVEL;
    endcase

    busy_d = (state_q != IDLE) || (fifo_count_s != FCW'(0));
  end

  // Transmitter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= CW'(0);
      phase_q   <= PW'(0);
      bit_idx_q <= 3'd0;
      shift_q   <= {DATA_BITS{1'b0}};
      line_q    <= IDLE_LEVEL;
      busy_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.serial_line = line_q;
  assign bus.busy        = busy_q;
  assign bus.full        = fifo_full_s;

endmodule

// File: tb/tb_serial_transmitter.sv
// Scoreboard bench for serial_transmitter: expected bytes are queued as writes
// are driven and popped as a line decoder reassembles each frame.
module tb_serial_transmitter;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int WRD   = 2;
  localparam int T     = 10;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic [7:0] tx_buf [0:31];
  int         tb_ph = 0;
  time        wr_t0 = 0;

  serial_transmitter_if bus ();

  serial_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .WR_DIV(WRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Independent model of the write-sample phase
  always @(posedge clk) begin
    if (rst)                tb_ph <= 0;
    else if (tb_ph == WRD-1) tb_ph <= 0;
    else                    tb_ph <= tb_ph + 1;
  end

  task automatic drive_writes(input int n);
    @(negedge clk);
    while (tb_ph != WRD-1) @(negedge clk);
    wr_t0 = $time;
    for (int i = 0; i < n; i++) begin
      bus.data  = tx_buf[i];
      bus.write = 1'b1;
      repeat (WRD) @(negedge clk);
    end
    bus.write = 1'b0;
  endtask

  task automatic rx_frame(input int limit, output logic [7:0] b, output time t_start,
                          output time t_end, output logic busy_s, output bit got);
    int   waited;
    bit   bad;
    logic p;
    waited = 0; bad = 1'b0;
    got = 1'b0; b = 8'h00; t_start = 0; t_end = 0; busy_s = 1'b0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.serial_line !== 1'b0 && waited < limit);
    if (bus.serial_line !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout: serial_line=%b after %0d cycles, expected start bit 0",
               bus.serial_line, waited);
      return;
    end
    t_start = $time;
    busy_s  = bus.busy;
    for (int i = 1; i < CPB; i++) begin
      @(negedge clk);
      if (bus.serial_line !== 1'b0) bad = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b[k] = bus.serial_line;
      for (int i = 1; i < CPB; i++) begin
        @(negedge clk);
        if (bus.serial_line !== b[k]) bad = 1'b1;
      end
    end
`ifdef SERIAL_TX_PARITY_EN
    @(negedge clk);
    p = bus.serial_line;
    for (int i = 1; i < CPB; i++) begin
      @(negedge clk);
      if (bus.serial_line !== p) bad = 1'b1;
    end
    vectors++;
    if (p !== ^b) begin
      miscompares++;
      $display("FAIL parity_bit: got %b, expected %b for byte %02h", p, ^b, b);
    end
`endif
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (bus.serial_line !== 1'b1) bad = 1'b1;
    end
    t_end = $time;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL frame_timing: bit not held %0d cycles or bad start/stop, byte %02h", CPB, b);
    end
    got = 1'b1;
  endtask

  task automatic rx_n(input int n, input bit contig, output time first_start, output time last_end);
    logic [7:0] b, e;
    time        ts, te, prev_end;
    logic       bs;
    bit         got;
    first_start = 0; last_end = 0; prev_end = 0;
    for (int k = 0; k < n; k++) begin
      rx_frame(300, b, ts, te, bs, got);
      if (!got) return;
      if (k == 0) first_start = ts;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_unexpected: got byte %02h, expected none", b);
      end else begin
        e = exp_q.pop_front();
        if (b !== e) begin
          miscompares++;
          $display("FAIL rx_byte: frame %0d got %02h, expected %02h", k, b, e);
        end
      end
      vectors++;
      if (bs !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_in_frame: busy=%b, expected 1", bs);
      end
      if (contig && k > 0) begin
        vectors++;
        if (ts != prev_end + T) begin
          miscompares++;
          $display("FAIL frame_gap: start at %0t, expected %0t", ts, prev_end + T);
        end
      end
      prev_end = te;
      last_end = te;
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.serial_line, bus.busy, bus.full} !== 3'b100) begin
        miscompares++;
        $display("FAIL idle_%s: cycle %0d line/busy/full=%b, expected 100",
                 tag, i, {bus.serial_line, bus.busy, bus.full});
      end
    end
  endtask

  task automatic test_reset();
    bus.write = 1'b0;
    bus.data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle(100, "reset");
  endtask

  task automatic test_single();
    time fs, le;
    tx_buf[0] = 8'h68;
    exp_q.push_back(8'h68);
    fork
      drive_writes(1);
      rx_n(1, 1'b0, fs, le);
    join
    vectors++;
    if (fs - wr_t0 != 3*T) begin
      miscompares++;
      $display("FAIL start_latency: %0t after write, expected %0t", fs - wr_t0, 3*T);
    end
    check_idle(60, "single");
  endtask

  task automatic test_back_to_back();
    time fs, le;
    logic [7:0] hello [6];
    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20};
    for (int i = 0; i < 6; i++) begin
      tx_buf[i] = hello[i];
      exp_q.push_back(hello[i]);
    end
    fork
      drive_writes(6);
      rx_n(6, 1'b1, fs, le);
    join
    vectors++;
    if (le - fs + T != 6*FRAME_BITS*CPB*T) begin
      miscompares++;
      $display("FAIL burst_length: %0t, expected %0t", le - fs + T, 6*FRAME_BITS*CPB*T);
    end
    check_idle(20, "burst");
  endtask

  task automatic test_overflow();
    time fs, le;
    bit  full_seen;
    full_seen = 1'b0;
    for (int i = 0; i < 20; i++) tx_buf[i] = 8'(i);
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(8'(i));
    fork
      drive_writes(20);
      rx_n(DEPTH + 1, 1'b1, fs, le);
      begin
        repeat (60) begin
          @(negedge clk);
          if (bus.full === 1'b1) full_seen = 1'b1;
        end
      end
    join
    vectors++;
    if (!full_seen) begin
      miscompares++;
      $display("FAIL full_flag: full never 1, expected 1 after %0d queued", DEPTH);
    end
    check_idle(100, "overflow");
  endtask

  task automatic test_reset_mid_frame();
    int w;
    w = 0;
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    exp_q.delete();
    fork
      drive_writes(4);
      begin
        do begin
          @(negedge clk);
          w++;
        end while (bus.serial_line !== 1'b0 && w < 100);
        repeat (3*CPB) @(negedge clk);
      end
    join
    vectors++;
    if (bus.busy !== 1'b1 || w >= 100) begin
      miscompares++;
      $display("FAIL pre_reset: busy=%b wait=%0d, expected busy 1 within 100", bus.busy, w);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.serial_line, bus.busy, bus.full} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_edge: line/busy/full=%b, expected 100",
               {bus.serial_line, bus.busy, bus.full});
    end
    @(negedge clk);
    rst = 1'b0;
    check_idle(200, "post_reset");
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    time fs, le;
    tx_buf[0] = 8'h07; tx_buf[1] = 8'h03;
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    fork
      drive_writes(2);
      rx_n(2, 1'b1, fs, le);
    join
    check_idle(10, "parity");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d expected bytes never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
